// File: rtl/game_pkg.sv
// Shared types and seven-segment constants for the guessing-game timer.
// Segment patterns are active-low, bit order gfedcba.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/game_timer_if.sv
// Request/status bundle between the game FSM (master) and game_timer (slave).
interface game_timer_if;

    logic       start;
    logic       clear;
    logic       seg3;
    logic       running;
    logic [3:0] remaining;
    logic [6:0] hex;

    modport master (
        output start, clear,
        input  seg3, running, remaining, hex
    );

    modport slave (
        input  start, clear,
        output seg3, running, remaining, hex
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low gfedcba decoder.
// Only compiled when GAME_TIMER_SEG7_EN is defined; nothing uses it otherwise.
`ifdef GAME_TIMER_SEG7_EN
module seg7_decoder
    import game_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule
`endif

// File: rtl/game_timer.sv
// Whole-second countdown that raises and holds seg3 on expiry for the game FSM.
// Define GAME_TIMER_SEG7_EN to get a registered seven-segment view of `remaining` on hex.
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SECONDS = 3
) (
    input  logic          clk,
    input  logic          reset,
    game_timer_if.slave   bus
);

    localparam int         PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [3:0] SEC_LOAD = 4'(SECONDS);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    rem_q,   rem_d;
    logic          seg3_q,  seg3_d;
    logic          run_q,   run_d;
    logic          wrap;

    // Full-width compare so no CLK_HZ value can alias to a shorter period.
    assign wrap = (32'(presc_q) == 32'(CLK_HZ - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        seg3_d  = seg3_q;
        run_d   = run_q;

        if (bus.clear) begin
            state_d = IDLE;
            presc_d = '0;
            rem_d   = '0;
            seg3_d  = 1'b0;
            run_d   = 1'b0;
        end else if (bus.start) begin
            state_d = RUN;
            presc_d = '0;
            rem_d   = SEC_LOAD;
            seg3_d  = 1'b0;
            run_d   = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (wrap) begin
                        presc_d = '0;
                        // Treating 0 like 1 keeps remaining from ever wrapping below zero.
                        if (rem_q <= 4'd1) begin
                            rem_d   = '0;
                            seg3_d  = 1'b1;
                            run_d   = 1'b0;
                            state_d = DONE;
                        end else begin
                            rem_d = rem_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                DONE:    ;
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            rem_q   <= '0;
            seg3_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, like real flops.
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            seg3_q  <= seg3_d;
            run_q   <= run_d;
        end
    end

    assign bus.seg3      = seg3_q;
    assign bus.running   = run_q;
    assign bus.remaining = rem_q;

`ifdef GAME_TIMER_SEG7_EN
    logic [6:0] seg_pat;
    logic [6:0] hex_q;

    seg7_decoder u_seg7 (
        .digit (rem_q),
        .seg   (seg_pat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hex_q <= SEG_BLANK;
        else        hex_q <= seg_pat;
    end

    assign bus.hex = hex_q;
`else
    assign bus.hex = SEG_BLANK;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer (CLK_HZ=4, SECONDS=3): directed scenarios plus
// randomized start/clear traffic against an elapsed-time model.
module tb_game_timer;

    localparam int HZ    = 4;
    localparam int SEC   = 3;
    localparam int TOTAL = HZ * SEC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    game_timer_if bus ();

    game_timer #(.CLK_HZ(HZ), .SECONDS(SEC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: "armed" flag plus cycles elapsed since the last restart.
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    logic [6:0] m_hex     = 7'h7F;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int exp_rem();
        if (!m_active || m_elapsed >= TOTAL) return 0;
        return SEC - m_elapsed / HZ;
    endfunction

    function automatic logic exp_run();
        return m_active && (m_elapsed < TOTAL);
    endfunction

    function automatic logic exp_seg3();
        return m_active && (m_elapsed >= TOTAL);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_elapsed <= 0;
            m_hex     <= 7'h7F;
        end else begin
`ifdef GAME_TIMER_SEG7_EN
            m_hex <= seg_of(exp_rem());
`endif
            if (bus.clear) begin
                m_active <= 1'b0;
            end else if (bus.start) begin
                m_active  <= 1'b1;
                m_elapsed <= 0;
            end else if (m_active && m_elapsed < TOTAL) begin
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Start high across exactly one rising edge; returns at the negedge after it.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.clear = 1'b0;
        rst_n     = 1'b0;
        cycles(2);
        checks++; if (bus.seg3 !== 1'b0)       begin errors++; $display("FAIL reset_seg3 got=%b exp=0", bus.seg3); end
        checks++; if (bus.running !== 1'b0)    begin errors++; $display("FAIL reset_running got=%b exp=0", bus.running); end
        checks++; if (bus.remaining !== 4'd0)  begin errors++; $display("FAIL reset_remaining got=%0d exp=0", bus.remaining); end
        checks++; if (bus.hex !== 7'h7F)       begin errors++; $display("FAIL reset_hex got=%h exp=7f", bus.hex); end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.running !== 1'b0 || bus.seg3 !== 1'b0 || bus.remaining !== 4'd0) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d got run=%b seg3=%b rem=%0d exp 0/0/0",
                         i, bus.running, bus.seg3, bus.remaining);
            end
        end
    endtask

    task automatic test_countdown();
        int exp_r;
        int prev_r;
        logic [6:0] exp_h;
        prev_r = 0;
        pulse_start();
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) @(negedge clk);
            exp_r = (i >= TOTAL) ? 0 : SEC - i / HZ;
            checks++; if (bus.remaining !== 4'(exp_r))
                begin errors++; $display("FAIL countdown_rem k+%0d got=%0d exp=%0d", i, bus.remaining, exp_r); end
            checks++; if (bus.seg3 !== (i >= TOTAL))
                begin errors++; $display("FAIL countdown_seg3 k+%0d got=%b exp=%b", i, bus.seg3, i >= TOTAL); end
            checks++; if (bus.running !== (i < TOTAL))
                begin errors++; $display("FAIL countdown_run k+%0d got=%b exp=%b", i, bus.running, i < TOTAL); end
            if (i > 0) begin
`ifdef GAME_TIMER_SEG7_EN
                exp_h = seg_of(prev_r);
`else
                exp_h = 7'h7F;
`endif
                checks++; if (bus.hex !== exp_h)
                    begin errors++; $display("FAIL countdown_hex k+%0d got=%h exp=%h", i, bus.hex, exp_h); end
            end
            prev_r = exp_r;
        end
    endtask

    task automatic test_restart();
        pulse_start();
        cycles(5);
        pulse_start();
        for (int j = 1; j <= TOTAL; j++) begin
            @(negedge clk);
            checks++; if (bus.seg3 !== (j == TOTAL))
                begin errors++; $display("FAIL restart_seg3 k+%0d got=%b exp=%b", j + 6, bus.seg3, j == TOTAL); end
        end
    endtask

    task automatic test_clear_vs_start();
        pulse_start();
        cycles(4);
        bus.start = 1'b1;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        checks++; if (bus.running !== 1'b0)   begin errors++; $display("FAIL clear_wins_run got=%b exp=0", bus.running); end
        checks++; if (bus.seg3 !== 1'b0)      begin errors++; $display("FAIL clear_wins_seg3 got=%b exp=0", bus.seg3); end
        checks++; if (bus.remaining !== 4'd0) begin errors++; $display("FAIL clear_wins_rem got=%0d exp=0", bus.remaining); end
        cycles(3);
        checks++; if (bus.running !== 1'b0)   begin errors++; $display("FAIL clear_stays_idle got=%b exp=0", bus.running); end
        pulse_start();
        cycles(TOTAL);
        checks++; if (bus.seg3 !== 1'b1)      begin errors++; $display("FAIL done_before_clear got=%b exp=1", bus.seg3); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++; if (bus.seg3 !== 1'b0)      begin errors++; $display("FAIL clear_in_done got=%b exp=0", bus.seg3); end
        checks++; if (bus.running !== 1'b0)   begin errors++; $display("FAIL clear_in_done_run got=%b exp=0", bus.running); end
    endtask

    task automatic test_async_reset();
        pulse_start();
        cycles(6);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.running !== 1'b0)   begin errors++; $display("FAIL async_run got=%b exp=0", bus.running); end
        checks++; if (bus.remaining !== 4'd0) begin errors++; $display("FAIL async_rem got=%0d exp=0", bus.remaining); end
        checks++; if (bus.seg3 !== 1'b0)      begin errors++; $display("FAIL async_seg3 got=%b exp=0", bus.seg3); end
        checks++; if (bus.hex !== 7'h7F)      begin errors++; $display("FAIL async_hex got=%h exp=7f", bus.hex); end
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        checks++; if (bus.running !== 1'b0)   begin errors++; $display("FAIL post_reset_idle got=%b exp=0", bus.running); end
        pulse_start();
        cycles(TOTAL - 1);
        checks++; if (bus.seg3 !== 1'b0)      begin errors++; $display("FAIL post_reset_early got=%b exp=0", bus.seg3); end
        cycles(1);
        checks++; if (bus.seg3 !== 1'b1)      begin errors++; $display("FAIL post_reset_expire got=%b exp=1", bus.seg3); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (bus.seg3 !== exp_seg3() || bus.running !== exp_run() ||
                bus.remaining !== 4'(exp_rem()) || bus.hex !== m_hex) begin
                errors++;
                $display("FAIL random cyc=%0d got seg3=%b run=%b rem=%0d hex=%h exp seg3=%b run=%b rem=%0d hex=%h",
                         i, bus.seg3, bus.running, bus.remaining, bus.hex,
                         exp_seg3(), exp_run(), exp_rem(), m_hex);
            end
            bus.start = ($urandom_range(0, 15) == 0);
            bus.clear = ($urandom_range(0, 31) == 0);
        end
        bus.start = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.clear = 1'b0;
        test_reset();
        test_countdown();
        test_restart();
        test_clear_vs_start();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/game_timer.md
# game_timer

Timeout generator that produces the `seg3` expiry level consumed by the guessing-game FSM. A start pulse arms a countdown of `SECONDS` whole seconds, derived from the board clock by an internal prescaler. On expiry the block holds `seg3` high until the FSM restarts or clears it. It sits beside the FSM in the game top level, driven by the FSM's start/clear requests.

## Interface
- `CLK_HZ`, default 50_000_000: board clock frequency; prescaler period in cycles (≥2).
- `SECONDS`, default 3: countdown length in seconds (1..15).
- `clk` in 1: board clock, rising-edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (asserted when 0).
- `start` in 1: restart request, sampled each edge; a level held high re-arms every cycle.
- `clear` in 1: abort request; priority over `start`.
- `seg3` out 1: expiry level to the FSM, registered.
- `running` out 1: high while counting, registered.
- `remaining` out 4: whole seconds left, registered.
- `hex` out 7: active-low seven-segment pattern of `remaining` (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `seg3`=0, `running`=0, `remaining`=0, prescaler=0, `hex`=7'h7F.
- Priority every edge, any state: `clear` → IDLE; else `start` → RUN (reload); else normal progress.
- Reload: prescaler←0, `remaining`←SECONDS, `running`←1, `seg3`←0.
- RUN: prescaler increments each cycle. At prescaler==CLK_HZ-1 it wraps to 0 and `remaining` decrements.
- Expiry: the wrap when `remaining`==1 sets `remaining`←0, `seg3`←1, `running`←0, state DONE.
- DONE: `seg3` held high indefinitely. `start` restarts and `seg3` drops on that same edge. `clear` → IDLE with `seg3`=0.
- IDLE: all counters frozen at 0; `seg3`=0.
- Prescaler width is $clog2(CLK_HZ). Compare against CLK_HZ-1 at full width, with no truncation.
- `remaining` never underflows. No decrement occurs outside RUN.

## Timing
- `start` sampled at edge k: `running`=1 and `remaining`=SECONDS are visible after edge k.
- `seg3` rises after edge k + SECONDS·CLK_HZ, with no extra pipeline stage.
- `remaining` decrements after edges k + n·CLK_HZ, for n = 1..SECONDS.
- `start` during RUN restarts the full interval, measured from the new edge.
- `start` and `clear` on the same edge: `clear` wins, giving IDLE.
- `reset` asserted mid-count: outputs go to reset values immediately, without waiting for a clock. After deassertion the block stays in IDLE until `start`.
- `hex` is one cycle behind `remaining` when the feature is enabled (registered decode).

## Configuration
- `GAME_TIMER_SEG7_EN` defined:
  - `hex` is a registered seven-segment decode of `remaining`, digits 0–F, active-low, segment order gfedcba.
  - Reset value is 7'h7F.
- Not defined:
  - `hex` is tied to 7'h7F (blank).
  - No decoder logic is instantiated.
  - All other behaviour is identical.

## Structure
- Shared package `game_pkg`:
  - state enum (IDLE, RUN, DONE);
  - seven-segment pattern constants for 0–F;
  - blank constant 7'h7F.
- Sub-module `seg7_decoder`: combinational, 4-bit in, 7-bit active-low out. Instantiated only under `GAME_TIMER_SEG7_EN`; the output register lives in `game_timer`.

## Test plan
Bench uses CLK_HZ=4, SECONDS=3.
- Reset: hold `reset`=0 with `start`=1 → `seg3`=0, `running`=0, `remaining`=0, `hex`=7'h7F. Release, keep `start`=0 → stays IDLE for 20 cycles.
- Countdown: `start` pulse at edge k → `remaining` 3, 2, 1 at k, k+4, k+8. `seg3`=1 and `remaining`=0 after k+12. `seg3` still 1 at k+30.
- Restart mid-run: `start` at k, again at k+6 → `seg3` rises after k+18, not k+12.
- Clear vs start: both high at k+5 during RUN → IDLE, `seg3`=0, `remaining`=0. `clear` alone in DONE → `seg3` drops next edge.
- Async reset: drop `reset` at k+7 between edges → outputs at reset values before the next edge. Restart after release → full 12-cycle interval.
- Display (`GAME_TIMER_SEG7_EN` on): during countdown `hex` shows 7'h30 (3), 7'h24 (2), 7'h79 (1), 7'h40 (0), each one cycle after `remaining` changes. Macro off → `hex`=7'h7F throughout.
